// File: rtl/wb_scoreboard_if.sv
// Issue/retire/kill bus between the pipeline and the register scoreboard.
// The scoreboard drives back the ID-stall request and its status counters.
interface wb_scoreboard_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_rd_wren;
    logic [4:0]  wb_rd;
    logic        wb_rd_wren;
    logic        kill_valid;
    logic [4:0]  kill_rd;
    logic        stall;
    logic [31:0] stall_cycles;
    logic        err_underflow;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_wren,
        output wb_rd, wb_rd_wren, kill_valid, kill_rd,
        input  stall, stall_cycles, err_underflow
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_wren,
        input  wb_rd, wb_rd_wren, kill_valid, kill_rd,
        output stall, stall_cycles, err_underflow
    );
endinterface

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters; stall is combinational (0 cycles) from state + ID/WB inputs.
// Backpressure: stall holds ID on RAW hazards or when the destination counter is full.
module wb_scoreboard #(
    parameter int NREG      = 32,
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic           clk,
    input  logic           rst,
    wb_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam bit               BYPASS  = (WB_BYPASS != 0);

    logic [CNT_W-1:0] cnt_q [1:NREG-1];
    logic [CNT_W-1:0] cnt_d [1:NREG-1];
    logic [31:0]      stall_cycles_q, stall_cycles_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
    logic             rs1_haz, rs2_haz, struct_stall;
    logic             stall, issue;
    logic             inc, ret, kil;
    logic [CNT_W+1:0] sum, dec, diff;

    function automatic logic [CNT_W-1:0] cnt_of(input logic [4:0] idx);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int r = 1; r < NREG; r++) begin
            if (idx == 5'(r)) c = cnt_q[r];
        end
        return c;
    endfunction

    always_comb begin
        rs1_cnt = cnt_of(sb.id_rs1);
        rs2_cnt = cnt_of(sb.id_rs2);
        rd_cnt  = cnt_of(sb.id_rd);

        // With write-through, the last pending write retiring this cycle no longer blocks the reader.
        rs1_haz = sb.id_rs1_used && (sb.id_rs1 != 5'd0) && (rs1_cnt != '0) &&
                  !(BYPASS && (rs1_cnt == CNT_ONE) && sb.wb_rd_wren && (sb.wb_rd == sb.id_rs1));
        rs2_haz = sb.id_rs2_used && (sb.id_rs2 != 5'd0) && (rs2_cnt != '0) &&
                  !(BYPASS && (rs2_cnt == CNT_ONE) && sb.wb_rd_wren && (sb.wb_rd == sb.id_rs2));
        struct_stall = sb.id_rd_wren && (sb.id_rd != 5'd0) && (rd_cnt == CNT_MAX) &&
                       !(sb.wb_rd_wren && (sb.wb_rd == sb.id_rd)) &&
                       !(sb.kill_valid && (sb.kill_rd == sb.id_rd));

        stall = sb.id_valid && (rs1_haz || rs2_haz || struct_stall);
        issue = sb.id_valid && !stall && sb.id_rd_wren && (sb.id_rd != 5'd0);
    end

    always_comb begin
        err_d = err_q;
        inc   = 1'b0;
        ret   = 1'b0;
        kil   = 1'b0;
        sum   = '0;
        dec   = '0;
        diff  = '0;
        for (int r = 1; r < NREG; r++) begin
            inc  = issue && (sb.id_rd == 5'(r));
            ret  = sb.wb_rd_wren && (sb.wb_rd == 5'(r));
            kil  = sb.kill_valid && (sb.kill_rd == 5'(r));
            sum  = {2'b00, cnt_q[r]} + {{(CNT_W+1){1'b0}}, inc};
            dec  = {{(CNT_W+1){1'b0}}, ret} + {{(CNT_W+1){1'b0}}, kil};
            diff = sum - dec;
            if (sum < dec) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else begin
                cnt_d[r] = diff[CNT_W-1:0];
            end
        end

        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < NREG; r++) cnt_q[r] <= '0;
            stall_cycles_q <= '0;
            err_q          <= 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) cnt_q[r] <= cnt_d[r];
            stall_cycles_q <= stall_cycles_d;
            err_q          <= err_d;
        end
    end

    assign sb.stall         = stall;
    assign sb.stall_cycles  = stall_cycles_q;
    assign sb.err_underflow = err_q;
endmodule

// File: tb/tb_wb_scoreboard.sv
// Drives a write-through and a registered-release scoreboard with the same stimulus
// and checks both against a counter-array reference model.
module tb_wb_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       t_v, t_u1, t_u2, t_rdw, t_wbw, t_kv;
    logic [4:0] t_rs1, t_rs2, t_rd, t_wbrd, t_krd;

    wb_scoreboard_if sb_b ();
    wb_scoreboard_if sb_n ();

    assign sb_b.id_valid = t_v;    assign sb_n.id_valid = t_v;
    assign sb_b.id_rs1 = t_rs1;    assign sb_n.id_rs1 = t_rs1;
    assign sb_b.id_rs2 = t_rs2;    assign sb_n.id_rs2 = t_rs2;
    assign sb_b.id_rs1_used = t_u1; assign sb_n.id_rs1_used = t_u1;
    assign sb_b.id_rs2_used = t_u2; assign sb_n.id_rs2_used = t_u2;
    assign sb_b.id_rd = t_rd;      assign sb_n.id_rd = t_rd;
    assign sb_b.id_rd_wren = t_rdw; assign sb_n.id_rd_wren = t_rdw;
    assign sb_b.wb_rd = t_wbrd;    assign sb_n.wb_rd = t_wbrd;
    assign sb_b.wb_rd_wren = t_wbw; assign sb_n.wb_rd_wren = t_wbw;
    assign sb_b.kill_valid = t_kv; assign sb_n.kill_valid = t_kv;
    assign sb_b.kill_rd = t_krd;   assign sb_n.kill_rd = t_krd;

    wb_scoreboard #(.NREG(32), .CNT_W(2), .WB_BYPASS(1)) dut_b (.clk(clk), .rst(rst), .sb(sb_b));
    wb_scoreboard #(.NREG(32), .CNT_W(2), .WB_BYPASS(0)) dut_n (.clk(clk), .rst(rst), .sb(sb_n));

    // Reference state: index 0 = write-through instance, 1 = registered-release instance.
    int      m_cnt [2][32];
    bit      m_err [2];
    longint  m_sc  [2];
    int      total = 0;
    int      bad   = 0;

    function automatic bit m_haz(int i, logic [4:0] s, logic used);
        int e;
        e = m_cnt[i][s];
        if (i == 0 && t_wbw && t_wbrd == s && e > 0) e = e - 1;
        return used && (s != 0) && (e != 0);
    endfunction

    function automatic bit m_stall(int i);
        bit st;
        st = t_rdw && (t_rd != 0) && (m_cnt[i][t_rd] == 3) &&
             !(t_wbw && t_wbrd == t_rd) && !(t_kv && t_krd == t_rd);
        return t_v && (m_haz(i, t_rs1, t_u1) || m_haz(i, t_rs2, t_u2) || st);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 32; r++) m_cnt[i][r] = 0;
            m_err[i] = 0;
            m_sc[i]  = 0;
        end
    endtask

    task automatic model_clock();
        bit st, iss;
        int n;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            st  = m_stall(i);
            iss = t_v && !st && t_rdw && (t_rd != 0);
            if (st && m_sc[i] < 64'hFFFF_FFFF) m_sc[i] = m_sc[i] + 1;
            for (int r = 1; r < 32; r++) begin
                n = m_cnt[i][r];
                if (iss && t_rd == r) n = n + 1;
                if (t_wbw && t_wbrd == r) n = n - 1;
                if (t_kv && t_krd == r) n = n - 1;
                if (n < 0) begin
                    n = 0;
                    m_err[i] = 1;
                end
                m_cnt[i][r] = n;
            end
        end
    endtask

    task automatic check(string tag, longint obs, longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t obs=%0d exp=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rdw,
                        input logic [4:0] wbrd, input logic wbw,
                        input logic kv, input logic [4:0] krd, input logic r);
        @(negedge clk);
        rst = r; t_v = v; t_rs1 = rs1; t_u1 = u1; t_rs2 = rs2; t_u2 = u2;
        t_rd = rd; t_rdw = rdw; t_wbrd = wbrd; t_wbw = wbw; t_kv = kv; t_krd = krd;
        #1;
        check("stall_byp",   longint'(sb_b.stall),         longint'(m_stall(0)));
        check("stall_nobyp", longint'(sb_n.stall),         longint'(m_stall(1)));
        check("cycles_byp",  longint'(sb_b.stall_cycles),  m_sc[0]);
        check("cycles_nobyp", longint'(sb_n.stall_cycles), m_sc[1]);
        check("err_byp",     longint'(sb_b.err_underflow), longint'(m_err[0]));
        check("err_nobyp",   longint'(sb_n.err_underflow), longint'(m_err[1]));
        @(posedge clk);
        model_clock();
    endtask

    initial begin
        t_v = 0; t_u1 = 0; t_u2 = 0; t_rdw = 0; t_wbw = 0; t_kv = 0;
        t_rs1 = 0; t_rs2 = 0; t_rd = 0; t_wbrd = 0; t_krd = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state, then issue x5 and read it until it retires.
        step(0, 0,0, 0,0, 0,0, 0,0, 0,0, 0);
        step(1, 0,0, 0,0, 5,1, 0,0, 0,0, 0);
        step(1, 5,1, 0,0, 0,0, 0,0, 0,0, 0);
        step(1, 5,1, 0,0, 0,0, 0,0, 0,0, 0);
        step(1, 5,1, 0,0, 0,0, 5,1, 0,0, 0);
        step(1, 5,1, 0,0, 0,0, 0,0, 0,0, 0);
        step(1, 5,1, 0,0, 0,0, 0,0, 0,0, 0);

        // x0 is never tracked.
        step(1, 0,0, 0,0, 0,1, 0,0, 0,0, 0);
        step(1, 0,1, 0,1, 0,0, 0,0, 0,0, 0);
        step(0, 0,0, 0,0, 0,0, 0,1, 1,0, 0);

        // Counter saturation on x7 and retire-in-same-cycle release.
        repeat (3) step(1, 0,0, 0,0, 7,1, 0,0, 0,0, 0);
        step(1, 0,0, 0,0, 7,1, 0,0, 0,0, 0);
        step(1, 0,0, 0,0, 7,1, 7,1, 0,0, 0);
        repeat (3) step(0, 0,0, 0,0, 0,0, 7,1, 0,0, 0);
        step(1, 7,1, 0,0, 0,0, 0,0, 0,0, 0);
        step(1, 7,1, 0,0, 0,0, 7,1, 0,0, 0);
        step(1, 7,1, 0,0, 0,0, 0,0, 0,0, 0);

        // Kill removes the pending write; a later retire underflows.
        step(1, 0,0, 0,0, 9,1, 0,0, 0,0, 0);
        step(0, 0,0, 0,0, 0,0, 0,0, 1,9, 0);
        step(1, 0,0, 9,1, 0,0, 0,0, 0,0, 0);
        step(0, 0,0, 0,0, 0,0, 9,1, 0,0, 0);
        step(1, 0,0, 9,1, 0,0, 0,0, 0,0, 0);

        // Reset while a hazard is held.
        step(1, 0,0, 0,0, 5,1, 0,0, 0,0, 0);
        step(1, 5,1, 0,0, 0,0, 0,0, 0,0, 0);
        step(1, 5,1, 0,0, 0,0, 0,0, 0,0, 1);
        step(1, 5,1, 0,0, 0,0, 0,0, 0,0, 0);

        // Random traffic over a small register window to provoke collisions.
        for (int k = 0; k < 800; k++) begin
            step($urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
                 5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0, 5'($urandom_range(0, 7)),
                 k == 400);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
